// File: rtl/add_sub_pkg.sv
// Shared types and constants for the sequential chunked adder/subtractor.
package add_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_sub_slice.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its MSB
// so the parent can form signed overflow on the final chunk.
module add_sub_slice #(
   parameter int unsigned CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout,
   output logic             cmsb
);

   logic [CHUNK:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int i = 0; i < int'(CHUNK); i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[CHUNK];
      cmsb = c[CHUNK-1];
   end

endmodule

// File: rtl/add_sub_seq.sv
// Multi-cycle two's-complement adder/subtractor: one shared CHUNK-bit ripple
// slice walks the operands LSB-first, with valid/ready on both sides.
module add_sub_seq
   import add_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_res,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             out_neg
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
         $error("add_sub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
      end
   endgenerate

   state_t           state;
   state_t           state_n;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             c_q;

   logic [31:0]      off;
   logic [CHUNK-1:0] sl_a;
   logic [CHUNK-1:0] sl_b;
   logic [CHUNK-1:0] sl_sum;
   logic             sl_cout;
   logic             sl_cmsb;
   logic [WIDTH-1:0] res_n;
   logic             last;

   // Select the active chunk and merge the slice sum back into the result.
   assign off   = 32'(k) * CHUNK;
   assign sl_a  = CHUNK'(a_q >> off);
   assign sl_b  = CHUNK'(b_q >> off);
   assign res_n = (res_q & ~(WIDTH'({CHUNK{1'b1}}) << off)) | (WIDTH'(sl_sum) << off);
   assign last  = (k == KW'(N - 1));

   add_sub_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .cin  (c_q),
      .sum  (sl_sum),
      .cout (sl_cout),
      .cmsb (sl_cmsb)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (in_valid)  state_n = BUSY;
         BUSY:    if (last)      state_n = DONE;
         DONE:    if (out_ready) state_n = IDLE;
         default:                state_n = IDLE;
      endcase
   end

   // Operand capture, chunk walk and registered result/flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         k         <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         c_q       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_res   <= '0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b0;
         out_neg   <= 1'b0;
      end else begin
         in_ready  <= (state_n == IDLE);
         out_valid <= (state_n == DONE);
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= (in_op == OP_SUB) ? ~in_b : in_b;
                  c_q   <= in_cin;
                  res_q <= '0;
                  k     <= '0;
               end
            end
            BUSY: begin
               res_q <= res_n;
               c_q   <= sl_cout;
               k     <= k + KW'(1);
               if (last) begin
                  k        <= '0;
                  out_res  <= res_n;
                  out_cout <= sl_cout;
                  out_ovf  <= sl_cmsb ^ sl_cout;
                  out_zero <= (res_n == '0);
                  out_neg  <= res_n[WIDTH-1];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_add_sub_seq.sv
// Bench for add_sub_seq: transaction-level model checked every cycle against a
// CHUNK=4 instance, plus directed literal vectors on it and a CHUNK=16 instance.
module tb_add_sub_seq;

   localparam int unsigned W  = 16;
   localparam int unsigned NA = 4;
   localparam int unsigned NB = 1;

   typedef struct packed {
      logic [15:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          a_in_valid, a_in_ready, a_in_op, a_in_cin, a_out_valid, a_out_ready;
   logic [W-1:0]  a_in_a, a_in_b, a_out_res;
   logic          a_out_cout, a_out_ovf, a_out_zero, a_out_neg;

   logic          b_in_valid, b_in_ready, b_in_op, b_in_cin, b_out_valid, b_out_ready;
   logic [W-1:0]  b_in_a, b_in_b, b_out_res;
   logic          b_out_cout, b_out_ovf, b_out_zero, b_out_neg;

   add_sub_seq #(.WIDTH(W), .CHUNK(4)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_a(a_in_a), .in_b(a_in_b), .in_op(a_in_op), .in_cin(a_in_cin),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_res(a_out_res), .out_cout(a_out_cout), .out_ovf(a_out_ovf),
      .out_zero(a_out_zero), .out_neg(a_out_neg)
   );

   add_sub_seq #(.WIDTH(W), .CHUNK(16)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_a(b_in_a), .in_b(b_in_b), .in_op(b_in_op), .in_cin(b_in_cin),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_res(b_out_res), .out_cout(b_out_cout), .out_ovf(b_out_ovf),
      .out_zero(b_out_zero), .out_neg(b_out_neg)
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Plain wide arithmetic reference for one operation.
   function automatic res_t compute(input logic [15:0] a, input logic [15:0] b,
                                    input logic op, input logic cin);
      res_t        r;
      logic [15:0] bb;
      logic [16:0] s;
      bb     = op ? ~b : b;
      s      = {1'b0, a} + {1'b0, bb} + 17'(cin);
      r.res  = s[15:0];
      r.cout = s[16];
      r.ovf  = (a[15] == bb[15]) && (s[15] != a[15]);
      r.zero = (s[15:0] == 16'h0);
      r.neg  = s[15];
      return r;
   endfunction

   // Transaction model of instance A: phase 0 idle, 1 busy, 2 done.
   int   m_phase = 0;
   int   m_cnt   = 0;
   bit   m_live  = 1'b0;
   res_t m_pend;
   res_t m_held;

   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         m_cnt   = 0;
         m_held  = '0;
         m_live  = 1'b1;
      end else begin
         case (m_phase)
            0: if (a_in_valid) begin
                  m_pend  = compute(a_in_a, a_in_b, a_in_op, a_in_cin);
                  m_cnt   = 0;
                  m_phase = 1;
               end
            1: begin
                  m_cnt++;
                  if (m_cnt == int'(NA)) begin
                     m_phase = 2;
                     m_held  = m_pend;
                  end
               end
            default: if (a_out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("cyc in_ready",  32'(a_in_ready),  32'(m_phase == 0));
         check("cyc out_valid", 32'(a_out_valid), 32'(m_phase == 2));
         check("cyc out_res",   32'(a_out_res),   32'(m_held.res));
         check("cyc out_cout",  32'(a_out_cout),  32'(m_held.cout));
         check("cyc out_ovf",   32'(a_out_ovf),   32'(m_held.ovf));
         check("cyc out_zero",  32'(a_out_zero),  32'(m_held.zero));
         check("cyc out_neg",   32'(a_out_neg),   32'(m_held.neg));
      end
   end

   // Issue one operation at #1 after an edge while idle and check literal results.
   task automatic run_op(input int sel, input string name,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic op, input logic cin,
                         input logic [15:0] er, input logic ec, input logic eo,
                         input logic ez, input logic en, input int lat);
      int   cyc;
      logic v;
      logic rdy;
      res_t got;
      if (sel == 0) begin
         a_in_a = a; a_in_b = b; a_in_op = op; a_in_cin = cin; a_in_valid = 1'b1;
      end else begin
         b_in_a = a; b_in_b = b; b_in_op = op; b_in_cin = cin; b_in_valid = 1'b1;
      end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      b_in_valid = 1'b0;
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         v = (sel == 0) ? a_out_valid : b_out_valid;
      end while (!v && cyc < 20);
      check({name, " latency"}, 32'(cyc), 32'(lat));
      if (sel == 0) got = {a_out_res, a_out_cout, a_out_ovf, a_out_zero, a_out_neg};
      else          got = {b_out_res, b_out_cout, b_out_ovf, b_out_zero, b_out_neg};
      check({name, " res"},  32'(got.res),  32'(er));
      check({name, " cout"}, 32'(got.cout), 32'(ec));
      check({name, " ovf"},  32'(got.ovf),  32'(eo));
      check({name, " zero"}, 32'(got.zero), 32'(ez));
      check({name, " neg"},  32'(got.neg),  32'(en));
      rdy = (sel == 0) ? a_out_ready : b_out_ready;
      if (rdy) begin
         @(posedge clk); #1;
         check({name, " ready back"}, 32'((sel == 0) ? a_in_ready : b_in_ready), 32'd1);
      end
   endtask

   initial begin
      rst = 1'b1;
      a_in_valid = 1'b0; a_in_a = '0; a_in_b = '0; a_in_op = 1'b0; a_in_cin = 1'b0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_a = '0; b_in_b = '0; b_in_op = 1'b0; b_in_cin = 1'b0; b_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset a in_ready",  32'(a_in_ready),  32'd1);
      check("reset a out_valid", 32'(a_out_valid), 32'd0);
      check("reset a out_res",   32'(a_out_res),   32'd0);
      check("reset b in_ready",  32'(b_in_ready),  32'd1);
      check("reset b out_valid", 32'(b_out_valid), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_op(0, "add 1234+1",    16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0, NA);
      run_op(0, "add 7fff+1",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, NA);
      run_op(0, "add ffff+1",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, NA);
      run_op(0, "add cin a5+5a", 16'h00A5, 16'h005A, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, NA);
      run_op(0, "sub 5-5",       16'h0005, 16'h0005, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, NA);
      run_op(0, "sub 0-1",       16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1, NA);
      run_op(0, "sub 8000-1",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, NA);
      run_op(0, "sub borrow",    16'h0010, 16'h0001, 1'b1, 1'b0, 16'h000E, 1'b1, 1'b0, 1'b0, 1'b0, NA);

      // Backpressure: result must hold and new operands must be ignored.
      a_out_ready = 1'b0;
      run_op(0, "bp 1111+2222",  16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, NA);
      for (int i = 0; i < 5; i++) begin
         a_in_valid = (i % 2) == 0;
         a_in_a     = 16'($urandom);
         @(posedge clk); #1;
         check("bp hold res",      32'(a_out_res),   32'h3333);
         check("bp hold valid",    32'(a_out_valid), 32'd1);
         check("bp in_ready low",  32'(a_in_ready),  32'd0);
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp release in_ready",  32'(a_in_ready),  32'd1);
      check("bp release out_valid", 32'(a_out_valid), 32'd0);
      check("bp release res kept",  32'(a_out_res),   32'h3333);

      // Abort mid-operation at chunk 2.
      a_in_a = 16'hABCD; a_in_b = 16'h1111; a_in_op = 1'b0; a_in_cin = 1'b0; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort in_ready",  32'(a_in_ready),  32'd1);
      check("abort out_valid", 32'(a_out_valid), 32'd0);
      check("abort out_res",   32'(a_out_res),   32'd0);
      check("abort flags",     32'({a_out_cout, a_out_ovf, a_out_zero, a_out_neg}), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      run_op(0, "post-abort add", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0, NA);

      // Single-chunk build.
      run_op(1, "n1 add 1234+1", 16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0, 1'b0, 1'b0, NB);
      run_op(1, "n1 sub 8000-1", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, NB);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/add_sub_seq.md
# add_sub_seq

Parametrised, multi-cycle two's-complement adder/subtractor that processes a WIDTH-bit operand pair CHUNK bits per clock through a single shared ripple slice. It carries a stored carry between chunks and reports carry, signed overflow, zero and negative flags. Operands arrive and results leave over valid/ready handshakes. It is the area-lean arithmetic unit that datapaths instantiate in place of a full-width combinational adder/subtractor.

## Interface
- WIDTH, 16: operand/result width; must be ≥ 2.
- CHUNK, 4: bits processed per cycle; WIDTH % CHUNK must be 0, otherwise elaboration fails. N = WIDTH/CHUNK.
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  1  0 = add, 1 = subtract.
- in_cin  input  1  add: carry-in; subtract: carry-in with carry convention (0 = borrow).
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_res  output  WIDTH  result.
- out_cout  output  1  carry out of bit WIDTH-1 (subtract: 1 = no borrow).
- out_ovf  output  1  signed overflow.
- out_zero  output  1  out_res == 0.
- out_neg  output  1  out_res[WIDTH-1].

## Operation
- Add: res = A + B + cin. Subtract: res = A + ~B + cin. A − B therefore requires cin = 1. Chained subtraction passes the previous cout.
- FSM states:
  - IDLE: in_ready = 1.
  - BUSY: chunk counter k = 0..N−1.
  - DONE: out_valid = 1.
- IDLE → BUSY on in_valid && in_ready. On that edge:
  - latch A;
  - latch B, or ~B when op = 1;
  - load the carry register with cin;
  - clear the result register;
  - k := 0.
- BUSY, each cycle:
  - slice adds A[k*CHUNK +: CHUNK], B'[k*CHUNK +: CHUNK] and the carry register;
  - the sum is written to result bits [k*CHUNK +: CHUNK];
  - the carry register takes the slice carry-out;
  - k increments.
  - On k = N−1, also capture the flags and move to DONE.
- Overflow = carry into MSB XOR carry out of MSB, taken from the final chunk.
- DONE → IDLE on out_valid && out_ready. No direct DONE → BUSY transition.
- in_a, in_b, in_op and in_cin are sampled only on the accept edge. Later changes to them are ignored.
- in_valid outside IDLE is ignored; no operand set is queued.
- Result and flag outputs are registered and held stable from out_valid rising until the output handshake. Between operations they keep their last values.
- rst in any state, including mid-BUSY, aborts the operation:
  - state := IDLE, k := 0;
  - out_valid = 0, in_ready = 1 on the cycle after the reset edge;
  - out_res, out_cout, out_ovf, out_zero and out_neg = 0.
- Reset values: every output 0 except in_ready = 1.

## Timing
- Input accept at edge E0. BUSY occupies cycles E0..E0+N. out_valid rises after edge E0+N, so latency is N cycles from accept edge to out_valid.
- With out_ready held high, the result is consumed on the first DONE edge and in_ready returns on the next cycle.
- Throughput: one operation per N+2 cycles.
- Output backpressure of any length holds the block in DONE with in_ready = 0.
- CHUNK = WIDTH (N = 1) is legal: out_valid rises 1 cycle after accept.

## Structure
- Shared package add_sub_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - op encoding constants OP_ADD = 1'b0 and OP_SUB = 1'b1.
- Sub-module add_sub_slice: combinational CHUNK-bit ripple adder.
  - Ports: a, b, cin, sum, cout, plus carry into MSB for overflow.
  - One instance only.
- Top holds the FSM, the chunk counter, the operand/result/carry registers and the flag logic.

## Test plan
All scenarios use WIDTH = 16, CHUNK = 4.
1. Add 0x1234 + 0x0001, cin = 0 → res 0x1235, cout 0, ovf 0, zero 0, neg 0. out_valid exactly 4 cycles after the accept edge.
2. Add 0x7FFF + 0x0001, cin = 0 → res 0x8000, ovf 1, neg 1, cout 0. Also add 0xFFFF + 0x0001 → res 0x0000, cout 1, zero 1, ovf 0.
3. Subtract 0x0005 − 0x0005, cin = 1 → res 0x0000, zero 1, cout 1. Subtract 0x0000 − 0x0001, cin = 1 → res 0xFFFF, cout 0, neg 1, ovf 0. Subtract 0x8000 − 0x0001, cin = 1 → res 0x7FFF, ovf 1.
4. Hold out_ready low 5 cycles in DONE while toggling in_valid and in_a → outputs unchanged, in_ready 0, no second operation started. Raise out_ready → IDLE next cycle.
5. Assert rst in BUSY at k = 2 → next cycle all outputs 0 and in_ready 1. Then add 0x00FF + 0x0001 → res 0x0100, correct latency.
6. Rebuild with CHUNK = 16, run scenario 1 → out_valid 1 cycle after accept, same result and flags.
